// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states, memory size.
// No logic of its own; used by load_store_unit and load_extend.
// Size helper maps the 2-bit size code to a byte count (0 for the reserved code).
package lsu_pkg;

  localparam int unsigned LSU_MEM_BYTES = 1024;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result formatting: right-justified assembled bytes to a 32-bit register value.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  size_i,
  input  logic        is_signed_i,
  output logic [31:0] data_o
);

  // Byte/half results fill the upper bits with the item MSB when signed, else zero
  always_comb begin
    data_o = bytes_i;
    case (size_i)
      SIZE_BYTE: data_o = {{24{is_signed_i & bytes_i[7]}}, bytes_i[7:0]};
      SIZE_HALF: data_o = {{16{is_signed_i & bytes_i[15]}}, bytes_i[15:0]};
      default:   data_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a byte-wide big-endian data memory.
// Latency: n byte cycles after acceptance plus one response cycle (error: response next cycle).
// Backpressure: req_ready only in IDLE; requests offered while busy are ignored, not queued.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = LSU_MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  req_n;
  logic [32:0] req_end;
  logic        req_bad;
  logic        last_byte;
  logic [31:0] load_shift;
  logic [31:0] load_ext;

  // Decode the offered request: byte count, alignment and range legality
  always_comb begin
    req_n   = size_bytes(req_size);
    req_end = {1'b0, req_addr} + {30'b0, req_n};
    case (req_size)
      SIZE_HALF: req_bad = req_addr[0];
      SIZE_WORD: req_bad = |req_addr[1:0];
      SIZE_RSVD: req_bad = 1'b1;
      default:   req_bad = 1'b0;
    endcase
    if (req_end > MEM_LIMIT) req_bad = 1'b1;
  end

  // Loads shift bytes in from the right, so the lowest address ends up most significant
  assign last_byte  = (idx_q == last_q);
  assign load_shift = {data_q[23:0], mem_rdata};

  load_extend u_load_extend (
    .bytes_i     (load_shift),
    .size_i      (size_q),
    .is_signed_i (sgn_q),
    .data_o      (load_ext)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_bad ? RESP : ACCESS;
      ACCESS:  if (last_byte) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: request latch, byte walk, response capture
  always_comb begin
    write_d = write_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          idx_d   = 2'd0;
          last_d  = 2'(req_n - 3'd1);
          // Stores are pre-aligned so the item's MSB sits in the top byte
          if (!req_write)                data_d = 32'h0;
          else if (req_size == SIZE_BYTE) data_d = {req_wdata[7:0], 24'h0};
          else if (req_size == SIZE_HALF) data_d = {req_wdata[15:0], 16'h0};
          else                            data_d = req_wdata;
          if (req_bad) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end
      ACCESS: begin
        idx_d  = idx_q + 2'd1;
        data_d = write_q ? {data_q[23:0], 8'h0} : load_shift;
        if (last_byte) begin
          err_d   = 1'b0;
          rdata_d = write_q ? 32'h0 : load_ext;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; response fields persist until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= 32'h0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      data_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs: memory port is active only during ACCESS, quiet (all zero) otherwise
  always_comb begin
    req_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_addr   = 32'h0;
    mem_wdata  = 8'h0;
    mem_we     = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr = addr_q + {30'b0, idx_q};
      if (write_q) begin
        mem_we    = 1'b1;
        mem_wdata = data_q[31:24];
      end
    end
  end

endmodule
